// File: rtl/apb_regfile_pkg.sv
// Shared types and limits for the APB register file.
package apb_regfile_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam int MAX_WAIT_STATES = 7;
  localparam int MAX_NUM_REGS    = 64;
  localparam int WAIT_W          = $clog2(MAX_WAIT_STATES + 1);

endpackage

// File: rtl/apb_regfile_decode.sv
// Combinational address decode: word index, window hit and transfer error.
module apb_regfile_decode
  import apb_regfile_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter logic [31:0]         BASE_ADDR  = 32'h0000_1200,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter int                  IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit,
  output logic                  err
);

  localparam int                  LSB       = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BASE      = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;
  logic                  below_base;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  ro_write;

  assign below_base   = paddr < BASE;
  assign offset       = paddr - BASE;
  assign word         = offset >> LSB;
  assign out_of_range = word >= REG_LIMIT;
  assign misaligned   = (offset & LANE_MASK) != '0;
  assign idx          = word[IDX_W-1:0];
  assign hit          = ~below_base & ~out_of_range & ~misaligned;
  // RO lookup is only meaningful once the index is known to be inside the window
  assign ro_write     = pwrite & hit & RO_MASK[idx];
  assign err          = ~hit | ro_write;

endmodule

// File: rtl/apb_regfile.sv
// APB slave register file with optional wait states, byte strobes and
// read-only registers that reflect hardware inputs.
module apb_regfile
  import apb_regfile_pkg::*;
#(
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  NUM_REGS    = 8,
  parameter logic [31:0]         BASE_ADDR   = 32'h0000_1200,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [IDX_W-1:0]               idx;
  logic                           hit;
  logic                           err;
  state_t                         state_reg, state_next;
  logic [WAIT_W-1:0]              wait_cnt_reg, wait_cnt_next;
  logic [NUM_REGS-1:0]            wr_pulse_reg;
  logic [NUM_REGS*DATA_WIDTH-1:0] rd_all;
  logic                           ready_int;
  logic                           complete;
  logic                           commit;

  apb_regfile_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .RO_MASK    (RO_MASK),
    .IDX_W      (IDX_W)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .idx    (idx),
    .hit    (hit),
    .err    (err)
  );

  assign ready_int = (state_reg == ST_ACCESS) && (wait_cnt_reg == '0);
  assign complete  = ready_int & psel & penable;
  // preset gating keeps a transfer that completes on the reset edge from committing
  assign commit    = complete & pwrite & ~err & ~preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_next    = ST_ACCESS;
          wait_cnt_next = WAIT_W'(WAIT_STATES);
        end
      end
      ST_ACCESS: begin
        if (!psel || complete) begin
          state_next = ST_IDLE;
        end else if (wait_cnt_reg != '0) begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH]  = '0;
      assign rd_all[gi*DATA_WIDTH +: DATA_WIDTH] = hw_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q_reg;
      logic                  unused_hw;
      assign unused_hw = ^hw_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
      for (genvar gj = 0; gj < NB; gj++) begin : g_lane
        always_ff @(posedge pclk) begin
          if (preset) begin
            q_reg[gj*8 +: 8] <= '0;
          end else if (commit && (idx == IDX_W'(gi)) && pstrb[gj]) begin
            q_reg[gj*8 +: 8] <= pwdata[gj*8 +: 8];
          end
        end
      end
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH]  = q_reg;
      assign rd_all[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
    end

    always_ff @(posedge pclk) begin
      if (preset) begin
        wr_pulse_reg[gi] <= 1'b0;
      end else begin
        wr_pulse_reg[gi] <= commit && (idx == IDX_W'(gi));
      end
    end
  end

  assign wr_pulse = wr_pulse_reg;
  assign pready   = ready_int & ~preset;
  assign pslverr  = complete & err & ~preset;
  assign prdata   = (complete && !pwrite && hit && !preset) ?
                    rd_all[idx*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_apb_regfile.sv
// Directed bench: dut0 has no wait states and register 7 read-only,
// dut1 has three wait states; both share the APB address/data bus.
module tb_apb_regfile;

  logic         pclk = 1'b0;
  logic         preset;
  logic [31:0]  paddr;
  logic         psel0, psel1, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [31:0]  prdata0, prdata1;
  logic [255:0] hw_rdata0, hw_rdata1, reg_q0, reg_q1;
  logic [7:0]   wr_pulse0, wr_pulse1;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 pclk = ~pclk;

  apb_regfile #(.WAIT_STATES(0), .RO_MASK(8'h80)) dut0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0),
    .prdata(prdata0), .pslverr(pslverr0), .hw_rdata(hw_rdata0), .reg_q(reg_q0),
    .wr_pulse(wr_pulse0)
  );

  apb_regfile #(.WAIT_STATES(3), .RO_MASK(8'h00)) dut1 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready1),
    .prdata(prdata1), .pslverr(pslverr1), .hw_rdata(hw_rdata1), .reg_q(reg_q1),
    .wr_pulse(wr_pulse1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One full APB transfer; reports completion data and wr_pulse over the two following cycles.
  task automatic apb_xfer(input int which, input logic [31:0] addr, input logic wr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic slverr, output int waits,
                          output logic [7:0] wp1, output logic [7:0] wp2);
    @(negedge pclk);
    paddr = addr; pwrite = wr; pwdata = data; pstrb = strb; penable = 1'b0;
    if (which == 0) psel0 = 1'b1; else psel1 = 1'b1;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    waits = 0;
    while (!((which == 0) ? pready0 : pready1) && waits < 20) begin
      @(negedge pclk);
      #1;
      waits++;
    end
    if (waits >= 20) check("pready_timeout", 64'(waits), 64'd0);
    rdata  = (which == 0) ? prdata0 : prdata1;
    slverr = (which == 0) ? pslverr0 : pslverr1;
    @(posedge pclk);
    #1;
    wp1 = (which == 0) ? wr_pulse0 : wr_pulse1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(posedge pclk);
    #1;
    wp2 = (which == 0) ? wr_pulse0 : wr_pulse1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        se;
    int          w;
    logic [7:0]  p1, p2;

    preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    hw_rdata0 = {32'h5A5A5A5A, 32'h66666666, 32'h55555555, 32'h44444444,
                 32'h33333333, 32'h22222222, 32'h11111111, 32'h01010101};
    hw_rdata1 = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready", 64'(pready0), 64'd0);
    check("rst_prdata", 64'(prdata0), 64'd0);
    check("rst_pslverr", 64'(pslverr0), 64'd0);
    check("rst_reg_q", 64'(reg_q0[63:0]), 64'd0);
    check("rst_wr_pulse", 64'(wr_pulse0), 64'd0);
    preset = 1'b0;

    apb_xfer(0, 32'h1204, 1'b1, 32'hDEADBEEF, 4'hF, rd, se, w, p1, p2);
    check("wr1204_slverr", 64'(se), 64'd0);
    check("wr1204_waits", 64'(w), 64'd0);
    check("wr1204_pulse", 64'(p1), 64'h02);
    check("wr1204_pulse_once", 64'(p2), 64'h00);
    check("wr1204_reg_q", 64'(reg_q0[63:32]), 64'hDEADBEEF);
    apb_xfer(0, 32'h1204, 1'b0, 32'h0, 4'h0, rd, se, w, p1, p2);
    check("rd1204_data", 64'(rd), 64'hDEADBEEF);
    check("rd1204_slverr", 64'(se), 64'd0);
    check("rd1204_no_pulse", 64'(p1), 64'h00);

    apb_xfer(0, 32'h1208, 1'b1, 32'h11223344, 4'hF, rd, se, w, p1, p2);
    apb_xfer(0, 32'h1208, 1'b1, 32'hAABBCCDD, 4'b0101, rd, se, w, p1, p2);
    check("strb_reg2", 64'(reg_q0[95:64]), 64'h11BB33DD);
    check("strb_pulse", 64'(p1), 64'h04);
    apb_xfer(0, 32'h1208, 1'b0, 32'hFFFFFFFF, 4'hF, rd, se, w, p1, p2);
    check("strb_rd_reg2", 64'(rd), 64'h11BB33DD);

    apb_xfer(0, 32'h1220, 1'b0, 32'h0, 4'h0, rd, se, w, p1, p2);
    check("rd1220_slverr", 64'(se), 64'd1);
    check("rd1220_data", 64'(rd), 64'd0);
    apb_xfer(0, 32'h1202, 1'b1, 32'hCAFEF00D, 4'hF, rd, se, w, p1, p2);
    check("wr1202_slverr", 64'(se), 64'd1);
    check("wr1202_no_pulse", 64'(p1), 64'h00);
    check("wr1202_reg0", 64'(reg_q0[31:0]), 64'd0);
    check("wr1202_reg1", 64'(reg_q0[63:32]), 64'hDEADBEEF);
    apb_xfer(0, 32'h11FC, 1'b0, 32'h0, 4'h0, rd, se, w, p1, p2);
    check("rd11FC_slverr", 64'(se), 64'd1);

    apb_xfer(0, 32'h121C, 1'b1, 32'h12345678, 4'hF, rd, se, w, p1, p2);
    check("wrRO_slverr", 64'(se), 64'd1);
    check("wrRO_no_pulse", 64'(p1), 64'h00);
    check("wrRO_reg_q", 64'(reg_q0[255:224]), 64'd0);
    apb_xfer(0, 32'h121C, 1'b0, 32'h0, 4'h0, rd, se, w, p1, p2);
    check("rdRO_data", 64'(rd), 64'h5A5A5A5A);
    check("rdRO_slverr", 64'(se), 64'd0);

    apb_xfer(0, 32'h1200, 1'b1, 32'hFFFFFFFF, 4'h0, rd, se, w, p1, p2);
    check("strb0_pulse", 64'(p1), 64'h01);
    check("strb0_reg0", 64'(reg_q0[31:0]), 64'd0);

    apb_xfer(1, 32'h1210, 1'b1, 32'h12345678, 4'hF, rd, se, w, p1, p2);
    check("ws3_waits", 64'(w), 64'd3);
    check("ws3_pulse", 64'(p1), 64'h10);
    check("ws3_reg4", 64'(reg_q1[159:128]), 64'h12345678);

    // Abort: psel drops in the second ACCESS cycle
    @(negedge pclk);
    paddr = 32'h1214; pwrite = 1'b1; pwdata = 32'h99999999; pstrb = 4'hF; psel1 = 1'b1;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel1 = 1'b0; penable = 1'b0;
    repeat (5) begin
      @(posedge pclk);
      #1;
      check("abort_no_pulse", 64'(wr_pulse1), 64'h00);
    end
    check("abort_reg5", 64'(reg_q1[191:160]), 64'd0);
    check("abort_idle_pready", 64'(pready1), 64'd0);

    // Reset lands on what would otherwise be the completion edge
    @(negedge pclk);
    paddr = 32'h120C; pwrite = 1'b1; pwdata = 32'h77777777; pstrb = 4'hF; psel0 = 1'b1;
    @(negedge pclk);
    penable = 1'b1; preset = 1'b1;
    #1;
    check("rstmid_pready", 64'(pready0), 64'd0);
    check("rstmid_pslverr", 64'(pslverr0), 64'd0);
    @(posedge pclk);
    #1;
    check("rstmid_no_pulse", 64'(wr_pulse0), 64'h00);
    check("rstmid_reg3", 64'(reg_q0[127:96]), 64'd0);
    check("rstmid_reg1_cleared", 64'(reg_q0[63:32]), 64'd0);
    psel0 = 1'b0; penable = 1'b0; preset = 1'b0;
    @(posedge pclk);
    #1;
    check("rstmid_idle_pready", 64'(pready0), 64'd0);
    check("rstmid_idle_pulse", 64'(wr_pulse0), 64'h00);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb_regfile.md
APB_REGFILE -- requirements
Module: apb_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning APB data width, legal values 8, 16 or 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning APB address width, legal values 8 to 32.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning register count, a power of two from 1 to 64.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_1200, meaning window base, aligned to NUM_REGS*DATA_WIDTH/8.
REQ-005 SHALL have parameter WAIT_STATES, default 0, meaning extra ACCESS cycles before pready, 0 to 7.
REQ-006 SHALL have parameter RO_MASK, default all zeros (NUM_REGS bits), meaning bit i set makes register i read-only to APB.
REQ-007 SHALL have port pclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port preset, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have APB inputs: paddr [ADDR_WIDTH], psel 1, penable 1, pwrite 1, pwdata [DATA_WIDTH], pstrb [DATA_WIDTH/8].
REQ-010 SHALL have APB outputs: pready 1, prdata [DATA_WIDTH], pslverr 1.
REQ-011 SHALL have port hw_rdata, input [NUM_REGS*DATA_WIDTH]: hardware values returned on reads of RO registers.
REQ-012 SHALL have port reg_q, output [NUM_REGS*DATA_WIDTH]: current values of the RW registers (RO slices are 0).
REQ-013 SHALL have port wr_pulse, output [NUM_REGS]: one-cycle strobe on a committed write to register i.

Function
REQ-014 SHALL implement FSM states IDLE and ACCESS.
REQ-015 SHALL transition IDLE->ACCESS on psel=1, penable=0 (setup phase) and load wait counter = WAIT_STATES.
REQ-016 SHALL decrement the wait counter each ACCESS cycle while it is nonzero.
REQ-017 SHALL drive pready=1 in ACCESS only when counter==0; pready=0 otherwise, including in IDLE.
REQ-018 SHALL complete a transfer on psel & penable & pready; next state is IDLE (a new setup is then required).
REQ-019 SHALL abort when psel=0 in ACCESS before completion: go to IDLE with no write and no wr_pulse.
REQ-020 SHALL compute word index = (paddr - BASE_ADDR) >> log2(DATA_WIDTH/8).
REQ-021 SHALL flag an error if paddr < BASE_ADDR, the index is >= NUM_REGS, or the paddr byte-offset bits are nonzero.
REQ-022 SHALL also flag an error for a write to a register whose RO_MASK bit is set.
REQ-023 SHALL drive pslverr=1 only in the completion cycle of an errored transfer; an errored write SHALL NOT modify state.
REQ-024 SHALL update, on a committed write, only the byte lanes with pstrb[k]=1; pstrb=0 is a legal no-op write that still pulses wr_pulse.
REQ-025 SHALL drive prdata in the read completion cycle from the RW register or hw_rdata slice (RO); prdata SHALL be 0 on error and in all other cycles.
REQ-026 SHALL assert wr_pulse[i] in the cycle after a committed write to i, coincident with the new reg_q value.
REQ-027 SHALL ignore pwdata and pstrb during reads.
REQ-028 SHALL not latch any APB input values; paddr, pwrite and pwdata are sampled in the completion cycle (APB stability assumed).

Reset
REQ-029 SHALL, with preset=1 at a pclk edge, set state to IDLE, the wait counter to 0, all RW registers to 0, and wr_pulse to 0.
REQ-030 SHALL hold pready, pslverr and prdata at 0 during reset.
REQ-031 SHALL discard an in-flight transfer on reset assertion mid-ACCESS, with no register write.

Structure
REQ-032 SHALL keep FSM state encoding and the max WAIT_STATES/NUM_REGS constants in package apb_regfile_pkg.
REQ-033 SHALL use one sub-module, apb_regfile_decode: combinational index, hit and error generation from paddr/pwrite/RO_MASK.

Verification
REQ-034 SHALL cover: write 0xDEADBEEF to 0x1204 with pstrb=4'hF, then read 0x1204 -> prdata=0xDEADBEEF, pslverr=0, wr_pulse[1] pulses once.
REQ-035 SHALL cover: reg2=0x11223344, then write 0xAABBCCDD with pstrb=4'b0101 -> reg2=0x11BB33DD.
REQ-036 SHALL cover: read 0x1220 and write 0x1202 -> pslverr=1, prdata=0, no register change.
REQ-037 SHALL cover: WAIT_STATES=3, write -> pready low for 3 ACCESS cycles and high on the 4th; an abort at the 2nd ACCESS cycle -> no write.
REQ-038 SHALL cover: RO_MASK=8'h80, write 0x121C -> pslverr=1; read 0x121C with hw_rdata slice 7=0x5A5A5A5A -> prdata=0x5A5A5A5A.
REQ-039 SHALL cover: preset asserted mid-ACCESS of a write -> state IDLE, target register remains 0, no wr_pulse.
